// File: rtl/mdu_seq_pkg.sv
// Shared constants and helpers for the RV32M multiply/divide sequencer.
package mdu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int CNT_W = 5;

  // rs1 is treated as signed for everything except the fully unsigned ops
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // rs2 is signed only for the fully signed ops (MULHSU keeps it unsigned)
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the sequencer datapath on magnitudes.
// Multiply: acc = {hi, multiplier}; add mb to hi when acc[0], then shift right.
// Divide:   acc = {rem, dividend/quotient}; shift left, trial-subtract mb,
//           keep the difference and shift in a 1 when it did not go negative.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   mb,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN+1:0] diff;
  logic            ge;

  // select between one add-shift and one restoring trial subtract
  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
    rsh  = acc_i[2*XLEN-1:XLEN-1];
    diff = {1'b0, rsh} - {2'b00, mb};
    ge   = ~diff[XLEN+1];
    if (is_div)
      acc_o = {(ge ? diff[XLEN-1:0] : rsh[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    else
      acc_o = {sum, acc_i[XLEN-1:1]};
  end

endmodule

// File: rtl/mdu_seq.sv
// RV32M iterative multiply/divide sequencer: 32 steps on operand magnitudes,
// sign fix-up on the last step, divide special cases resolved without iterating.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  mdu_state_e        state;
  logic [2:0]        op;
  logic [XLEN-1:0]   mb;
  logic [2*XLEN-1:0] acc;
  logic              neg_a, neg_b;
  logic [CNT_W-1:0]  cnt;
  logic              done_q;
  logic [XLEN-1:0]   res_q;

  logic              sa_in, sb_in;
  logic [XLEN-1:0]   ma_in, mb_in;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin;

  // operand capture: sign flags, magnitudes and the no-iteration divide cases
  always_comb begin
    sa_in   = op_signed_a(funct3) & a[XLEN-1];
    sb_in   = op_signed_b(funct3) & b[XLEN-1];
    ma_in   = sa_in ? -a : a;
    mb_in   = sb_in ? -b : b;
    special = 1'b0;
    special_res = '0;
    if (funct3[2] && (b == '0)) begin
      special     = 1'b1;
      special_res = funct3[1] ? a : '1;
    end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div (op[2]),
    .acc_i  (acc),
    .mb     (mb),
    .acc_o  (acc_nxt)
  );

  // sign fix-up applied to the output of the final step
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    case (op)
      F3_MUL:                   fin = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:                 fin = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:          fin = (neg_a ^ neg_b) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      default:                  fin = neg_a ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  // sequencer FSM with counter, datapath state and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op     <= '0;
      mb     <= '0;
      acc    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // a flush in the same cycle drops the request
          if (start && !flush) begin
            op    <= funct3;
            mb    <= mb_in;
            acc   <= {{XLEN{1'b0}}, ma_in};
            neg_a <= sa_in;
            neg_b <= sb_in;
            cnt   <= '0;
            if (special) begin
              res_q  <= special_res;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(31)) begin
              res_q  <= fin;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // a flush landing on the done cycle suppresses the pulse
  assign done   = done_q & ~flush;
  assign result = res_q;
  assign busy   = (state != ST_IDLE);
  assign stall  = ((state == ST_IDLE) & start) | (state == ST_CALC);

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: scoreboard of expected results/done cycles.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done, stall;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  mdu_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference arithmetic, independent of the iterative datapath
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        p;
    logic signed [31:0] q;
    logic               ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p = '0;
    q = '0;
    case (f)
      3'd0: begin p = 64'(longint'($signed(x)) * longint'($signed(y))); return p[31:0]; end
      3'd1: begin p = 64'(longint'($signed(x)) * longint'($signed(y))); return p[63:32]; end
      3'd2: begin p = 64'(longint'($signed(x)) * longint'({32'h0, y})); return p[63:32]; end
      3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = $signed(x) / $signed(y); return q;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        q = $signed(x) % $signed(y); return q;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && ((y == 0) || (((f == 3'd4) || (f == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF))))
      return 1;
    return 33;
  endfunction

  // drive a request in the current cycle (caller is just past a falling edge)
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input int lat, input int hold);
    int t;
    start = 1'b1; funct3 = f; a = x; b = y;
    t = cyc;
    #1 chk("stall_req", {31'b0, stall}, 32'd1);
    sb.push_back('{res: r, cyc: t + lat});
    @(negedge clk);
    // later operand/funct3 changes must not matter
    for (int h = 0; h < hold; h++) begin
      a = $urandom; b = $urandom; funct3 = 3'($urandom);
      @(negedge clk);
    end
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
    if (hold == 0) #1 chk("stall_t1", {31'b0, stall}, (lat == 1) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    chk("idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  // scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  df [8];
    logic [31:0] da [8];
    logic [31:0] db [8];
    logic [31:0] dr [8];
    int t;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",   {31'b0, busy},  32'd0);
    chk("rst_done",   {31'b0, done},  32'd0);
    chk("rst_stall",  {31'b0, stall}, 32'd0);
    chk("rst_result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL 7 * -3 with a full stall/done trace
    @(negedge clk);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      chk("trace_stall", {31'b0, stall}, (k <= 32) ? 32'd1 : 32'd0);
      chk("trace_done",  {31'b0, done},  (k == 33) ? 32'd1 : 32'd0);
      chk("trace_busy",  {31'b0, busy},  32'd1);
    end
    wait_idle();

    // directed high products, divides and special cases
    df = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5};
    da = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
           32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5};
    db = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
           32'd2, 32'd7, 32'd7, 32'd0};
    dr = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(df[i], da[i], db[i], dr[i], (i == 7) ? 1 : 33, 0);
      wait_idle();
    end
    @(negedge clk);
    issue(3'd6, 32'd5, 32'd0, 32'd5, 1, 0);
    wait_idle();
    @(negedge clk);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    wait_idle();
    @(negedge clk);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    wait_idle();

    // flush at T+10, new request at T+11 done at T+44
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd100; b = 32'd7;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_cyc", 32'(cyc), 32'(t + 11));
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 33, 0);
    wait_idle();

    // start held high through the busy period: exactly one done
    @(negedge clk);
    issue(3'd7, 32'd1000, 32'd33, 32'd10, 33, 20);
    wait_idle();

    // asynchronous reset mid-op
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'b0, busy},  32'd0);
    chk("mid_rst_done",   {31'b0, done},  32'd0);
    chk("mid_rst_stall",  {31'b0, stall}, 32'd0);
    chk("mid_rst_result", result,         32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 33, 0);
    wait_idle();

    // random mix against the reference model
    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      @(negedge clk);
      issue(rf, ra, rb, model(rf, ra, rb), lat_of(rf, ra, rb), 0);
      wait_idle();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
